// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Holds the FSM state encoding, the reset PC default and the canonical NOP word.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;

    // A fetch address is unusable if it is not word aligned or lies past word last_idx.
    function automatic logic addr_bad(input logic [31:0] pc, input logic [31:0] last_idx);
        return (pc[1:0] != 2'b00) || ((pc >> 2) > last_idx);
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding an instruction word and its address.
// Absorbs a returning fetch while the output stage is stalled by decode.
module fetch_skid_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc
);

    logic        full;
    logic        push;
    logic [31:0] inst_q;
    logic [31:0] pc_q;

    assign in_ready  = !full || out_ready;
    assign push      = in_valid && in_ready && !flush;
    assign out_valid = full;
    assign out_inst  = inst_q;
    assign out_pc    = pc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 1'b0;
        end else if (flush) begin
            full <= 1'b0;
        end else if (push) begin
            full <= 1'b1;
        end else if (out_ready) begin
            full <= 1'b0;
        end
    end

    // NOTE: the payload registers carry no reset; full gates every use, so stale data never escapes.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_q <= in_inst;
            pc_q   <= in_pc;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues sequential fetches to a registered memory,
// buffers returning words behind a valid/ready decode interface, handles redirects and halt.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned N        = 20,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc_out,
    input  logic [31:0] inst_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic        halted,
    output logic        fault
);

    fetch_state_e state;
    logic         inflight;
    logic [31:0]  inflight_pc;

    logic         skid_in_ready;
    logic         skid_valid;
    logic [31:0]  skid_inst;
    logic [31:0]  skid_pc;

    logic         in_run;
    logic         accept;
    logic         out_free;
    logic         do_halt;
    logic         do_redirect;
    logic         redirect_bad;
    logic         pc_bad;
    logic         flush;
    logic         issue;
    logic         skid_push;

    // NOTE: every signal here gets a value on every pass, so no latch can be inferred.
    always_comb begin
        in_run       = (state == ST_RUN);
        accept       = if_valid && if_ready;
        out_free     = !if_valid || accept;
        do_halt      = in_run && halt_req;
        // Halt outranks redirect; a redirect coinciding with halt is dropped.
        do_redirect  = in_run && !halt_req && redirect_valid;
        redirect_bad = do_redirect && (redirect_pc[1:0] != 2'b00);
        pc_bad       = in_run && !halt_req && !redirect_valid && addr_bad(pc_out, 32'(N));
        flush        = do_redirect;
        issue        = in_run && !halt_req && !redirect_valid && !pc_bad && !skid_valid &&
                       (!inflight || out_free);
        skid_push    = inflight && !flush && !out_free && skid_in_ready;
    end

    fetch_skid_buf u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (skid_push),
        .in_ready  (skid_in_ready),
        .in_inst   (inst_in),
        .in_pc     (inflight_pc),
        .out_valid (skid_valid),
        .out_ready (out_free),
        .out_inst  (skid_inst),
        .out_pc    (skid_pc)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_BOOT;
            pc_out      <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            if_valid    <= 1'b0;
            if_inst     <= '0;
            if_pc       <= '0;
            halted      <= 1'b0;
            fault       <= 1'b0;
        end else begin
            case (state)
                ST_BOOT: state <= ST_RUN;
                ST_RUN: begin
                    if (do_halt || redirect_bad || pc_bad) begin
                        state <= ST_HALT;
                    end
                end
                default: state <= ST_HALT;
            endcase

            if (redirect_bad || pc_bad) begin
                fault <= 1'b1;
            end

            if (issue) begin
                inflight_pc <= pc_out;
                pc_out      <= pc_out + 32'd4;
            end else if (do_redirect && !redirect_bad) begin
                pc_out <= redirect_pc;
            end
            inflight <= issue;

            // Skid content is older than the in-flight word, so it refills the output first.
            if (flush) begin
                if_valid <= 1'b0;
                if_inst  <= INST_NOP;
                if_pc    <= '0;
            end else if (out_free) begin
                if (skid_valid) begin
                    if_valid <= 1'b1;
                    if_inst  <= skid_inst;
                    if_pc    <= skid_pc;
                end else if (inflight) begin
                    if_valid <= 1'b1;
                    if_inst  <= inst_in;
                    if_pc    <= inflight_pc;
                end else begin
                    if_valid <= 1'b0;
                end
            end

            halted <= (state == ST_HALT) && !if_valid && !skid_valid && !inflight;
        end
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL have parameter N, default 20: index of the last valid instruction word (memory holds words 0..N).
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 pc_out  output  32  address driven to instruction memory; memory returns the word one cycle later.
REQ-006 inst_in  input  32  registered instruction memory output; always the word at the pc_out of the previous cycle.
REQ-007 redirect_valid  input  1  branch/jump taken this cycle.
REQ-008 redirect_pc  input  32  redirect target.
REQ-009 halt_req  input  1  stop fetching (ecall/ebreak decoded).
REQ-010 if_valid  output  1  if_inst/if_pc hold a valid instruction for decode.
REQ-011 if_ready  input  1  decode accepts; transfer when if_valid and if_ready are both high.
REQ-012 if_inst  output  32  delivered instruction.
REQ-013 if_pc  output  32  address of if_inst.
REQ-014 halted  output  1  HALT state reached and no instruction buffered.
REQ-015 fault  output  1  sticky; misaligned or out-of-range fetch address.

Function
REQ-016 The FSM SHALL have states BOOT, RUN and HALT; BOOT lasts exactly one cycle after reset release, then RUN.
REQ-017 A fetch SHALL be issued in a RUN cycle when the skid buffer is empty and, if a fetch is in flight, the output stage is empty or being accepted that cycle.
REQ-018 On issue, the block SHALL capture inst_in and pc_out in the next cycle, then advance pc_out by 4 (modulo 2^32); pc_out SHALL hold when no fetch is issued.
REQ-019 A returning word SHALL go to the output stage if that stage is empty or is being accepted, otherwise to the one-entry skid buffer; no word SHALL be dropped or duplicated, and order SHALL be preserved.
REQ-020 If the output stage is accepted while the skid buffer is full, the skid content SHALL move to the output stage in the same cycle.
REQ-021 If redirect_valid is high in RUN, the block SHALL invalidate the in-flight fetch, the skid buffer and the output stage in that cycle, and set pc_out to redirect_pc for the next cycle.
REQ-022 A redirect arriving in the same cycle as an if_ready transfer SHALL let that transfer complete before the flush.
REQ-023 If redirect_pc[1:0] != 0, the block SHALL set fault, enter HALT and issue no fetch.
REQ-024 If (pc_out >> 2) > N while in RUN, the block SHALL set fault, enter HALT and issue no fetch; word N itself SHALL still be fetched.
REQ-025 On halt_req in RUN, the block SHALL enter HALT next cycle and stop issuing fetches, while in-flight and buffered words are still delivered.
REQ-026 When halt_req and redirect_valid coincide, halt SHALL win and the redirect SHALL be ignored.
REQ-027 halted SHALL be high in HALT once the output stage, skid buffer and in-flight slot are all empty.
REQ-028 HALT SHALL be exited only by reset.
REQ-029 if_inst and if_pc SHALL remain stable while if_valid is high and if_ready is low.

Reset
REQ-030 rst SHALL asynchronously force: state BOOT, pc_out=RESET_PC, if_valid=0, if_inst=0, if_pc=0, halted=0, fault=0, skid and in-flight flags cleared.
REQ-031 Reset asserted mid-operation SHALL discard all buffered words, and no word captured before reset SHALL be delivered after it.

Structure
REQ-032 A shared package fetch_pkg SHALL hold the FSM state enum, the RESET_PC default and the constant INST_NOP=32'h0000_0013.
REQ-033 The one-entry skid buffer SHALL be a sub-module named fetch_skid_buf, with flush input and valid/ready on both sides.

Verification
REQ-034 Bench SHALL cover: reset release with if_ready=1 and memory words 0..3 -> if_pc sequence 0,4,8,12 on consecutive cycles starting 2 cycles after BOOT.
REQ-035 Bench SHALL cover: if_ready low for 3 cycles after word 1 is presented -> word 1 held stable, word 2 in skid, then 2,3 delivered in order with no loss.
REQ-036 Bench SHALL cover: redirect_valid with redirect_pc=32'h10 while words 4 and 8 are buffered -> both discarded, next delivered if_pc=0x10.
REQ-037 Bench SHALL cover: N=3 with sequential run -> words 0..3 delivered, then fault=1, halted=1, no if_pc=0x10 delivered.
REQ-038 Bench SHALL cover: redirect_pc=32'h6 -> fault=1, HALT; halt_req coinciding with redirect -> redirect ignored, buffered words drained, then halted=1.
REQ-039 Bench SHALL cover: rst pulsed while the skid buffer is full -> all outputs zero asynchronously, restart at RESET_PC.
